// File: rtl/ghash_pkg.sv
// Shared GHASH constants, product width and sequencer state encoding.
// Bit order is reflected throughout: bit 127 of a block is the x^0 coefficient.
package ghash_pkg;

    localparam int unsigned NB_GHASH = 128;
    localparam int unsigned NB_PROD  = 2 * NB_GHASH - 1;

    // x^128 = x^7 + x^2 + x + 1, written in reflected order
    localparam logic [NB_GHASH-1:0] GHASH_R = {8'hE1, 120'h0};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE
    } ghash_state_e;

endpackage

// File: rtl/ghash_gf128_reduce.sv
// Combinational reduction of a 255-bit reflected carry-less product modulo
// x^128 + x^7 + x^2 + x + 1, folding the high-degree part twice through GHASH_R.
module ghash_gf128_reduce
    import ghash_pkg::*;
(
    input  logic [NB_PROD-1:0]  prod_i,
    output logic [NB_GHASH-1:0] red_o
);

    localparam int unsigned NB_WIDE = NB_GHASH + 8;

    logic [NB_GHASH-1:0] hi1;
    logic [NB_GHASH-1:0] hi2;
    logic [NB_GHASH-1:0] fold2;
    logic [NB_WIDE-1:0]  wide;
    logic [NB_WIDE-1:0]  fold1;

    // Right shift multiplies by x in reflected order; the first fold can spill
    // up to x^133, so it runs in an 8-bit wider window and the spill folds again.
    always_comb begin
        hi1   = {prod_i[NB_GHASH-2:0], 1'b0};
        wide  = {hi1, 8'h00};
        fold1 = '0;
        fold2 = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (GHASH_R[NB_GHASH-1-k]) begin
                fold1 = fold1 ^ (wide >> k);
            end
        end
        hi2 = {fold1[7:0], (NB_GHASH-8)'(0)};
        for (int unsigned k = 0; k < 8; k++) begin
            if (GHASH_R[NB_GHASH-1-k]) begin
                fold2 = fold2 ^ (hi2 >> k);
            end
        end
        red_o = prod_i[NB_PROD-1:NB_GHASH-1] ^ fold1[NB_WIDE-1:8] ^ fold2;
    end

endmodule

// File: rtl/ghash_koa_mult_sequencer.sv
// GHASH sequencer around an external pipelined GF(2^128) multiplier: X_i = (X_{i-1} ^ B_i) * H.
// Optional GHASH_SEQ_MULT_VALID_EN: leave WAIT on i_mult_valid instead of a fixed-latency counter.
module ghash_koa_mult_sequencer
    import ghash_pkg::*;
#(
    parameter int unsigned NB_DATA      = NB_GHASH,
    parameter int unsigned MULT_LATENCY = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic [NB_DATA-1:0]   i_h,
    input  logic                 i_h_load,
    input  logic [NB_DATA-1:0]   i_block,
    input  logic                 i_sop,
    input  logic                 i_eop,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NB_DATA-1:0]   o_mult_a,
    output logic [NB_DATA-1:0]   o_mult_b,
    output logic                 o_mult_valid,
    input  logic [2*NB_DATA-2:0] i_mult_data,
    input  logic                 i_mult_valid,
    output logic [NB_DATA-1:0]   o_ghash,
    output logic                 o_ghash_valid,
    output logic                 o_busy
);

    ghash_state_e          state_q;
    logic [NB_DATA-1:0]    acc_q;
    logic [NB_DATA-1:0]    h_q;
    logic [NB_DATA-1:0]    op_a_q;
    logic [NB_DATA-1:0]    op_b_q;
    logic                  mv_q;
    logic                  eop_q;
    logic [NB_DATA-1:0]    ghash_q;
    logic                  gv_q;
    logic [NB_DATA-1:0]    red;
    logic [2*NB_DATA-2:0]  prod;

`ifdef GHASH_SEQ_MULT_VALID_EN
    localparam int unsigned lat_unused = MULT_LATENCY;
    logic [2*NB_DATA-2:0]  prod_q;
    assign prod = prod_q;
`else
    localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  mult_valid_unused;
    assign mult_valid_unused = i_mult_valid;
    assign cnt_d             = cnt_q - CNT_W'(1);
    assign prod              = i_mult_data;
`endif

    ghash_gf128_reduce u_reduce (
        .prod_i (prod),
        .red_o  (red)
    );

    // Sequencer FSM with registered operands, accumulator and tag
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            h_q     <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            mv_q    <= 1'b0;
            eop_q   <= 1'b0;
            ghash_q <= '0;
            gv_q    <= 1'b0;
`ifdef GHASH_SEQ_MULT_VALID_EN
            prod_q  <= '0;
`else
            cnt_q   <= '0;
`endif
        end else begin
            mv_q <= 1'b0;
            gv_q <= 1'b0;
            if (i_clear) begin
                state_q <= IDLE;
                acc_q   <= '0;
                eop_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_h_load) begin
                            h_q <= i_h;
                        end else if (i_valid) begin
                            op_a_q  <= (i_sop ? '0 : acc_q) ^ i_block;
                            op_b_q  <= h_q;
                            mv_q    <= 1'b1;
                            eop_q   <= i_eop;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
`ifdef GHASH_SEQ_MULT_VALID_EN
                        state_q <= WAIT;
`else
                        if (MULT_LATENCY == 1) begin
                            state_q <= UPDATE;
                        end else begin
                            cnt_q   <= CNT_W'(MULT_LATENCY - 1);
                            state_q <= WAIT;
                        end
`endif
                    end
                    WAIT: begin
`ifdef GHASH_SEQ_MULT_VALID_EN
                        if (i_mult_valid) begin
                            prod_q  <= i_mult_data;
                            state_q <= UPDATE;
                        end
`else
                        cnt_q <= cnt_d;
                        if (cnt_d == '0) begin
                            state_q <= UPDATE;
                        end
`endif
                    end
                    UPDATE: begin
                        acc_q <= red;
                        if (eop_q) begin
                            ghash_q <= red;
                            gv_q    <= 1'b1;
                        end
                        eop_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_ready       = (state_q == IDLE) && !i_h_load;
    assign o_busy        = (state_q != IDLE);
    assign o_mult_a      = op_a_q;
    assign o_mult_b      = op_b_q;
    assign o_mult_valid  = mv_q;
    assign o_ghash       = ghash_q;
    assign o_ghash_valid = gv_q;

endmodule
